// File: rtl/cordic_atan.sv
// rtl/cordic_atan.sv - iterative vectoring CORDIC: first-quadrant (x, y) to quarter-phase, one micro-rotation per clock
// Optional magnitude output o_mag enabled by defining CORDIC_ATAN_MAG_EN.
module cordic_atan #(
    parameter int ITERS = 19
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [15:0] o_qph,
    output logic        o_valid,
`ifdef CORDIC_ATAN_MAG_EN
    output logic [16:0] o_mag,
`endif
    input  logic        i_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    localparam logic [4:0] LAST    = 5'(ITERS - 1);
    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_ZERO = 2'd1;
    localparam logic [1:0] SP_FULL = 2'd2;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [20:0] x_q, x_d, y_q, y_d;
    // One headroom bit above the 24-bit phase so overshoot past 90 deg cannot wrap.
    logic signed [24:0] p_q, p_d;
    logic [1:0]         spec_q, spec_d;
    logic [15:0]        qph_q, qph_d;
`ifdef CORDIC_ATAN_MAG_EN
    logic [16:0]        mag_q, mag_d;
`endif

    logic               accept;
    logic [4:0]         shamt;
    logic signed [20:0] x_sh, y_sh, x_in, y_in;
    logic signed [24:0] angle;

    // atan(2^-(i+1)) scaled so that 2^23 = 90 deg
    function automatic logic [22:0] atan_tab(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_tab = 23'd2476042;
            5'd1:    atan_tab = 23'd1308273;
            5'd2:    atan_tab = 23'd664100;
            5'd3:    atan_tab = 23'd333339;
            5'd4:    atan_tab = 23'd166832;
            5'd5:    atan_tab = 23'd83436;
            5'd6:    atan_tab = 23'd41721;
            5'd7:    atan_tab = 23'd20861;
            5'd8:    atan_tab = 23'd10430;
            5'd9:    atan_tab = 23'd5215;
            5'd10:   atan_tab = 23'd2608;
            5'd11:   atan_tab = 23'd1304;
            5'd12:   atan_tab = 23'd652;
            5'd13:   atan_tab = 23'd326;
            5'd14:   atan_tab = 23'd163;
            5'd15:   atan_tab = 23'd81;
            5'd16:   atan_tab = 23'd41;
            5'd17:   atan_tab = 23'd20;
            5'd18:   atan_tab = 23'd10;
            default: atan_tab = 23'd0;
        endcase
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ITER;
            S_ITER:  if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  if (i_ready) state_d = i_valid ? S_ITER : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ready in DONE follows i_ready so a consumed result and a new accept share one edge.
    always_comb begin
        o_valid = (state_q == S_DONE);
        o_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
        accept  = i_valid && o_ready;
    end

    always_comb begin
        shamt = cnt_q + 5'd1;
        x_sh  = x_q >>> shamt;
        y_sh  = y_q >>> shamt;
        angle = {2'b00, atan_tab(cnt_q)};
        x_in  = {3'b000, i_x, 2'b00};
        y_in  = {3'b000, i_y, 2'b00};
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        spec_d = spec_q;
        qph_d  = qph_q;
`ifdef CORDIC_ATAN_MAG_EN
        mag_d  = mag_q;
`endif
        if (accept) begin
            x_d   = x_in + y_in;
            y_d   = y_in - x_in;
            p_d   = 25'sh0400000;
            cnt_d = 5'd0;
            if (i_x == 16'd0 && i_y == 16'd0) spec_d = SP_ZERO;
            else if (i_x == 16'd0)            spec_d = SP_FULL;
            else if (i_y == 16'd0)            spec_d = SP_ZERO;
            else                              spec_d = SP_NONE;
        end else if (state_q == S_ITER) begin
            cnt_d = cnt_q + 5'd1;
            if (!y_q[20]) begin
                x_d = x_q + y_sh;
                y_d = y_q - x_sh;
                p_d = p_q + angle;
            end else begin
                x_d = x_q - y_sh;
                y_d = y_q + x_sh;
                p_d = p_q - angle;
            end
            if (cnt_q == LAST) begin
                if (spec_q == SP_ZERO)            qph_d = 16'h0000;
                else if (spec_q == SP_FULL)       qph_d = 16'hFFFF;
                else if (p_d[24])                 qph_d = 16'h0000;
                else if (p_d >= 25'sh0800000)     qph_d = 16'hFFFF;
                else                              qph_d = p_d[22:7];
`ifdef CORDIC_ATAN_MAG_EN
                mag_d = 17'((36'(x_d[20:2]) * 36'h9B75) >> 16);
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q    <= '0;
            y_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            spec_q <= SP_NONE;
            qph_q  <= '0;
`ifdef CORDIC_ATAN_MAG_EN
            mag_q  <= '0;
`endif
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            spec_q <= spec_d;
            qph_q  <= qph_d;
`ifdef CORDIC_ATAN_MAG_EN
            mag_q  <= mag_d;
`endif
        end
    end

    assign o_qph = qph_q;
`ifdef CORDIC_ATAN_MAG_EN
    assign o_mag = mag_q;
`endif

endmodule

// File: tb/tb_cordic_atan.sv
// tb/tb_cordic_atan.sv - self-checking bench for cordic_atan against an atan2/rotation model
module tb_cordic_atan;

    localparam int  ITERS = 19;
    localparam int  LAT   = ITERS + 1;
    localparam real PI    = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] x   = '0;
    logic [15:0] y   = '0;
    logic        vin = 1'b0;
    logic        rin = 1'b1;
    logic        rdy_o;
    logic [15:0] qph;
    logic        vout;
`ifdef CORDIC_ATAN_MAG_EN
    logic [16:0] mag;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int results = 0;

    typedef struct {int vx; int vy; int acc;} vec_t;
    vec_t exp_q[$];
    bit          seen = 1'b0;
    logic [15:0] held = '0;

    cordic_atan #(.ITERS(ITERS)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_x     (x),
        .i_y     (y),
        .i_valid (vin),
        .o_ready (rdy_o),
        .o_qph   (qph),
        .o_valid (vout),
`ifdef CORDIC_ATAN_MAG_EN
        .o_mag   (mag),
`endif
        .i_ready (rin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, act, act, req, req);
        end
    endtask

    function automatic int model_special(input int vx, input int vy);
        if (vx == 0 && vy == 0) return 0;
        if (vx == 0)            return 65535;
        if (vy == 0)            return 0;
        return -1;
    endfunction

    // Vectoring rotations with exact angles; returns phase in output LSBs, clamped.
    function automatic real model_e(input int vx, input int vy);
        longint xx, yy, t;
        real    p, a;
        xx = longint'(vx + vy) * 4;
        yy = longint'(vy - vx) * 4;
        p  = 4194304.0;
        for (int i = 0; i < ITERS; i++) begin
            a = $atan(1.0 / real'(longint'(1) << (i + 1))) * 8388608.0 / (PI / 2.0);
            t = xx;
            if (yy >= 0) begin
                xx = xx + (yy >>> (i + 1));
                yy = yy - (t >>> (i + 1));
                p  = p + a;
            end else begin
                xx = xx - (yy >>> (i + 1));
                yy = yy + (t >>> (i + 1));
                p  = p - a;
            end
        end
        p = p / 128.0;
        if (p < 0.0)       p = 0.0;
        if (p > 65535.999) p = 65535.999;
        return p;
    endfunction

    task automatic check_result(input int vx, input int vy, input int got);
        int  sp;
        real e, d, ideal;
        sp = model_special(vx, vy);
        if (sp >= 0) begin
            chk("special_case", got == sp, got, sp);
        end else begin
            e = model_e(vx, vy);
            d = real'(got) - e;
            chk("model_phase", d >= -1.25 && d <= 0.25, got, int'(e));
            if (vx >= 32768 || vy >= 32768) begin
                ideal = $atan2(real'(vy), real'(vx)) / (PI / 2.0) * 65536.0;
                if (ideal > 65535.0) ideal = 65535.0;
                d = real'(got) - ideal;
                chk("atan2_accuracy", d >= -3.0 && d <= 3.0, got, int'(ideal));
            end
        end
    endtask

    always @(negedge clk) begin : cmp
        vec_t v;
        real  m, dm;
        if (rst) begin
            exp_q.delete();
            seen = 1'b0;
        end else begin
            if (vout) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1'b0, int'(qph), 0);
                end else begin
                    v = exp_q[0];
                    if (!seen) begin
                        chk("latency", (cyc - v.acc) == LAT, cyc - v.acc, LAT);
                        seen = 1'b1;
                        held = qph;
                    end
                    chk("qph_stable", qph == held, int'(qph), int'(held));
                    check_result(v.vx, v.vy, int'(qph));
`ifdef CORDIC_ATAN_MAG_EN
                    m  = $sqrt(real'(v.vx) * real'(v.vx) + real'(v.vy) * real'(v.vy));
                    dm = real'(mag) - m;
                    chk("magnitude", dm >= -4.0 && dm <= 4.0, int'(mag), int'(m));
`endif
                    chk("ready_in_done", rdy_o == rin, int'(rdy_o), int'(rin));
                    if (rin) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                        results++;
                    end
                end
            end else if (exp_q.size() != 0) begin
                chk("ready_low_iter", rdy_o == 1'b0, int'(rdy_o), 0);
            end else begin
                chk("ready_idle", rdy_o == 1'b1, int'(rdy_o), 1);
            end
            if (vin && rdy_o) exp_q.push_back('{int'(x), int'(y), cyc});
        end
    end

    task automatic send(input logic [15:0] sx, input logic [15:0] sy);
        int n = 0;
        x   = sx;
        y   = sy;
        vin = 1'b1;
        @(negedge clk);
        while (!rdy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_o) chk("send_timeout", 1'b0, 0, 1);
        @(posedge clk);
        #1 vin = 1'b0;
    endtask

    task automatic wait_result(output logic [15:0] q);
        int n = 0;
        @(negedge clk);
        while (!vout && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!vout) chk("result_timeout", 1'b0, 0, 1);
        q = qph;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] q;
        int          n;
        int          target;
        real         e;

        e = model_e(32768, 32768);
        chk("pin_model_45deg", e >= 32765.0 && e <= 32771.0, int'(e), 32768);
        e = model_e(56754, 32767);
        chk("pin_model_30deg", e >= 21842.0 && e <= 21848.0, int'(e), 21845);
        chk("pin_model_yaxis", model_special(0, 5) == 65535, model_special(0, 5), 65535);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", vout == 1'b0, int'(vout), 0);
        chk("reset_qph", qph == 16'h0000, int'(qph), 0);
        chk("reset_ready", rdy_o == 1'b1, int'(rdy_o), 1);
        @(posedge clk);
        #1;

        send(16'hFFFF, 16'h0000); wait_result(q);
        chk("x_axis", q == 16'h0000, int'(q), 16'h0000);
        send(16'h0000, 16'hFFFF); wait_result(q);
        chk("y_axis", q == 16'hFFFF, int'(q), 16'hFFFF);
        send(16'h0000, 16'h0000); wait_result(q);
        chk("origin", q == 16'h0000, int'(q), 16'h0000);
        send(16'h8000, 16'h8000); wait_result(q);
        chk("deg45", q >= 16'h7FFD && q <= 16'h8003, int'(q), 16'h8000);
        send(16'hDDB2, 16'h7FFF); wait_result(q);
        chk("deg30", q >= 16'h5552 && q <= 16'h5558, int'(q), 16'h5555);

        rin = 1'b0;
        send(16'h1234, 16'h5678);
        n = 0;
        @(negedge clk);
        while (!vout && n < 60) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_held", vout == 1'b1, int'(vout), 1);
            chk("bp_ready_low", rdy_o == 1'b0, int'(rdy_o), 0);
        end
        @(posedge clk);
        #1;
        x   = 16'h4000;
        y   = 16'h2000;
        vin = 1'b1;
        rin = 1'b1;
        @(posedge clk);
        #1 vin = 1'b0;
        wait_result(q);

        send(16'h4321, 16'h1234);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", vout == 1'b0, int'(vout), 0);
        chk("rst_mid_ready", rdy_o == 1'b1, int'(rdy_o), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", vout == 1'b0, int'(vout), 0);
        chk("post_rst_ready", rdy_o == 1'b1, int'(rdy_o), 1);
        @(posedge clk);
        #1;
        send(16'h8000, 16'h0000); wait_result(q);
        chk("after_reset", q == 16'h0000, int'(q), 16'h0000);

        target = results + 1500;
        n = 0;
        while (results < target && n < 60000) begin
            x   = 16'($urandom);
            y   = 16'($urandom);
            if ($urandom_range(0, 7) == 0) x = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) y = 16'($urandom_range(0, 3));
            vin = ($urandom_range(0, 3) != 0);
            rin = ($urandom_range(0, 7) != 0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("random_budget", results >= target, results, target);
        vin = 1'b0;
        rin = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size() == 0, exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
